mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between EX and WB. Latches the EX/MEM bus under the common 6-bit stall protocol and performs the data-SRAM load/store handshake, holding the pipeline through CTRL until the response arrives. For loads it aligns and extends the returned word. It produces the MEM/WB bus consumed by WB and a forwarding bus to ID.

## Interface
- `EX_TO_MEM_WD`, 106: EX/MEM bus width. Fields, MSB→LSB:
  - pc[31:0]
  - mem_op[3:0]
  - rf_we
  - rf_waddr[4:0]
  - alu_result[31:0]
  - store_data[31:0]
- `MEM_TO_WB_WD`, 70: MEM/WB bus width. Fields: {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- `StallBus`, 6: stall vector width.
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  CTRL stall vector; this stage uses stall[3] and stall[4].
- ex_to_mem_bus  in  106  EX/MEM payload.
- data_sram_en  out  1  request valid.
- data_sram_wen  out  4  byte write enables (0 for loads).
- data_sram_addr  out  32  byte address (alu_result).
- data_sram_wdata  out  32  lane-replicated store data.
- data_sram_data_ok  in  1  response/completion strobe, sampled on posedge.
- data_sram_rdata  in  32  read data, valid when data_ok=1.
- stallreq_mem  out  1  hold-pipeline request to CTRL.
- mem_to_wb_bus  out  70  to WB.
- mem_to_id  out  38  forwarding {rf_we, rf_waddr, rf_wdata}.

## Operation
- mem_op encoding:
  - 0000: no access
  - 1000: LB
  - 1001: LBU
  - 1010: LH
  - 1011: LHU
  - 1100: LW
  - 1101: SB
  - 1110: SH
  - 1111: SW
  - Other values are treated as 0000.
- Pipeline register, priority order at posedge:
  1. rst → zero.
  2. stall[3]=Stop and stall[4]=NoStop → zero (bubble).
  3. stall[3]=NoStop → load ex_to_mem_bus.
  4. Otherwise hold.
- FSM states IDLE, WAIT, DONE. The access flag `acc` = latched mem_op[3].
  - IDLE: if acc, assert data_sram_en; data_ok → DONE, else → WAIT.
  - WAIT: keep data_sram_en=1 with identical addr/wen/wdata; data_ok → DONE.
  - DONE: data_sram_en=0. Return to IDLE on the cycle the pipeline register loads or bubbles (rules 2 or 3).
  - Rule 2 or 3 from any state also forces IDLE.
- On data_ok: capture data_sram_rdata into rdata_r.
- stallreq_mem = acc and state≠DONE.
- Store lanes (a = addr[1:0]):
  - SB: wen = 4'b0001<<a; wdata = {4{store_data[7:0]}}.
  - SH: wen = a[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - SW: wen = 1111; wdata = store_data.
- Load data, from rdata_r:
  - LB/LBU: byte a, sign-/zero-extended.
  - LH/LHU: halfword a[1], sign-/zero-extended.
  - LW: full word.
  - Alignment is EX's responsibility; addr[0] is ignored for halfwords, and no exception is raised here.
- rf_wdata = load result for loads, otherwise alu_result. Stores pass rf_we as latched (0 from EX).
- mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}.
- mem_to_id = {fwd_we, rf_waddr, rf_wdata}. fwd_we = rf_we, forced to 0 for a load not yet in DONE.

## Timing
- Reset: all of the following are 0, and the FSM is in IDLE:
  - pipeline register and rdata_r
  - data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  - stallreq_mem
  - mem_to_wb_bus and mem_to_id
- Non-memory ops: zero added latency; result visible the cycle after latch.
- Memory ops: with data_ok in the first MEM cycle, MEM occupancy is 2 cycles. Each extra cycle of data_ok delay adds one cycle.
- Once raised, data_sram_en stays high until data_ok is sampled. It is never dropped early, except on rst.
- data_ok while data_sram_en=0 is ignored.
- While stalled in DONE by a downstream/other stall, rdata_r and outputs stay stable. No second request is issued.
- Back-to-back memory ops: DONE→IDLE on load, so the new request is raised the cycle after the handover.
- rst mid-WAIT: request dropped the same posedge. A later stray data_ok is ignored (state IDLE, en=0).

## Test plan
- ALU op: pc=0xBFC00010, rf_we=1, waddr=5, alu_result=0x1234 → next cycle mem_to_wb_bus carries wdata=0x1234, stallreq_mem=0.
- LB, addr=0x80000003, data_ok after 3 cycles, rdata=0x80FF1122 → stallreq_mem high 3 cycles, en held stable throughout, rf_wdata=0xFFFFFF80. Same with LBU → 0x00000080.
- SH, addr=0x80000002, store_data=0xDEADBEEF → wen=1100, wdata=0xBEEFBEEF, en dropped after data_ok, rf_we=0.
- LW completes, then stall[4]=Stop for 2 cycles → DONE held, no re-request, stallreq_mem=0, fwd_we=1 with rdata.
- Bubble: stall[3]=Stop, stall[4]=NoStop → register zeroed, mem_to_wb_bus=0.
- rst asserted in WAIT, stray data_ok next cycle → all outputs 0, FSM IDLE, no capture.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : EX/MEM pipeline register, data-SRAM load/store handshake and
//            load-data alignment; drives the MEM/WB and ID forwarding buses.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int EX_TO_MEM_WD = 106,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_BUS    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    input  logic                    data_sram_data_ok,
    input  logic [31:0]             data_sram_rdata,
    output logic                    stallreq_mem,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_op_lb  = 4'b1000;
    localparam logic [3:0] c_op_lbu = 4'b1001;
    localparam logic [3:0] c_op_lh  = 4'b1010;
    localparam logic [3:0] c_op_lhu = 4'b1011;
    localparam logic [3:0] c_op_lw  = 4'b1100;
    localparam logic [3:0] c_op_sb  = 4'b1101;
    localparam logic [3:0] c_op_sh  = 4'b1110;
    localparam logic [3:0] c_op_sw  = 4'b1111;

    logic [EX_TO_MEM_WD-1:0] r_bus;
    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [31:0]             r_rdata;

    logic [31:0] w_pc;
    logic [3:0]  w_op;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_alu;
    logic [31:0] w_sdata;
    logic [1:0]  w_a;
    logic        w_advance;
    logic        w_bubble;
    logic        w_acc;
    logic        w_is_load;
    logic        w_en;
    logic        w_fwd_we;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rf_wdata;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata;
    logic        w_unused_stall;

    assign w_pc       = r_bus[105:74];
    assign w_op       = r_bus[73:70];
    assign w_rf_we    = r_bus[69];
    assign w_rf_waddr = r_bus[68:64];
    assign w_alu      = r_bus[63:32];
    assign w_sdata    = r_bus[31:0];
    assign w_a        = w_alu[1:0];

    assign w_advance      = ~stall[3];
    assign w_bubble       = stall[3] & ~stall[4];
    assign w_unused_stall = &{1'b0, stall[STALL_BUS-1:5], stall[2:0]};

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_bus <= '0;
        end else if (w_advance) begin
            r_bus <= ex_to_mem_bus;
        end
    end

    // Only 1xxx encodings touch memory; 1101..1111 are stores.
    assign w_acc     = w_op[3];
    assign w_is_load = w_acc && (w_op[2:0] <= 3'b100);
    assign w_en      = w_acc && ((r_state == c_st_idle) || (r_state == c_st_wait));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_acc) w_state_nxt = data_sram_data_ok ? c_st_done : c_st_wait;
            c_st_wait: if (data_sram_data_ok) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_done;
            default:   w_state_nxt = c_st_idle;
        endcase
        // A fresh instruction or bubble entering the register restarts the handshake.
        if (w_advance || w_bubble) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_en && data_sram_data_ok) begin
            r_rdata <= data_sram_rdata;
        end
    end

    always_comb begin
        w_wen   = 4'b0000;
        w_wdata = 32'd0;
        case (w_op)
            c_op_sb: begin
                w_wen   = 4'b0001 << w_a;
                w_wdata = {4{w_sdata[7:0]}};
            end
            c_op_sh: begin
                w_wen   = w_a[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_sdata[15:0]}};
            end
            c_op_sw: begin
                w_wen   = 4'b1111;
                w_wdata = w_sdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (w_a)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = w_a[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (w_op)
            c_op_lb:  w_rf_wdata = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_rf_wdata = {24'd0, w_byte};
            c_op_lh:  w_rf_wdata = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_rf_wdata = {16'd0, w_half};
            c_op_lw:  w_rf_wdata = r_rdata;
            default:  w_rf_wdata = w_alu;
        endcase
    end

    // Loads must not forward until the returned data has been captured.
    assign w_fwd_we = w_rf_we && !(w_is_load && (r_state != c_st_done));

    assign data_sram_en    = w_en;
    assign data_sram_wen   = w_en ? w_wen : 4'b0000;
    assign data_sram_addr  = w_alu;
    assign data_sram_wdata = w_wdata;
    assign stallreq_mem    = w_acc && (r_state != c_st_done);
    assign mem_to_wb_bus   = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_id       = {w_fwd_we, w_rf_waddr, w_rf_wdata};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Randomized self-checking bench for mem_stage against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

    localparam logic [5:0] c_run    = 6'b000000;
    localparam logic [5:0] c_hold   = 6'b011111;
    localparam logic [5:0] c_bubble = 6'b001111;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [105:0] ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         stallreq_mem;
    logic [69:0]  mem_to_wb_bus;
    logic [37:0]  mem_to_id;

    int n_chk  = 0;
    int n_pass = 0;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .stallreq_mem     (stallreq_mem),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id        (mem_to_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return op >= 4'd8;
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return op >= 4'd13;
    endfunction

    function automatic bit is_load(input logic [3:0] op);
        return is_mem(op) && !is_store(op);
    endfunction

    function automatic logic [3:0] ref_wen(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'd13:   return 4'(1 << addr[1:0]);
            4'd14:   return addr[1] ? 4'hC : 4'h3;
            4'd15:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] op, input logic [31:0] s);
        case (op)
            4'd13:   return {4{s[7:0]}};
            4'd14:   return {2{s[15:0]}};
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] bsh;
        logic [7:0]  b;
        logic [15:0] h;
        bsh = rd >> (8 * int'(addr[1:0]));
        b   = bsh[7:0];
        h   = addr[1] ? rd[31:16] : rd[15:0];
        case (op)
            4'd8:    return 32'($signed(b));
            4'd9:    return 32'(b);
            4'd10:   return 32'($signed(h));
            4'd11:   return 32'(h);
            4'd12:   return rd;
            default: return addr;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_en"},    data_sram_en,    0);
        chk({tag, "_wen"},   data_sram_wen,   0);
        chk({tag, "_addr"},  data_sram_addr,  0);
        chk({tag, "_wdata"}, data_sram_wdata, 0);
        chk({tag, "_stall"}, stallreq_mem,    0);
        chk({tag, "_wb"},    mem_to_wb_bus,   0);
        chk({tag, "_id"},    mem_to_id,       0);
    endtask

    // One instruction: latch, handshake with data_ok in wait cycle d, then
    // hold in the result phase for `hold` extra cycles, optionally bubble.
    task automatic run_op(input logic [31:0] pc, input logic [3:0] op, input logic we,
                          input logic [4:0] waddr, input logic [31:0] alu, input logic [31:0] sd,
                          input int d, input logic [31:0] rd, input int hold, input bit bub);
        logic [31:0] exp_wd;
        ex_to_mem_bus     = {pc, op, we, waddr, alu, sd};
        stall             = c_run;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        stall         = c_hold;
        ex_to_mem_bus = {$urandom, $urandom, $urandom, $urandom};
        if (is_mem(op)) begin
            for (int k = 0; k <= d; k++) begin
                chk("req_en",    data_sram_en,  1);
                chk("req_stall", stallreq_mem,  1);
                chk("req_addr",  data_sram_addr, alu);
                chk("req_wen",   data_sram_wen, ref_wen(op, alu));
                if (is_store(op)) chk("req_wdata", data_sram_wdata, ref_store(op, sd));
                chk("req_fwd_we", mem_to_id[37], is_load(op) ? 1'b0 : we);
                data_sram_data_ok = (k == d);
                data_sram_rdata   = (k == d) ? rd : $urandom;
                @(negedge clk);
            end
            data_sram_data_ok = 1'b0;
        end
        exp_wd = is_load(op) ? ref_result(op, alu, rd) : alu;
        for (int h = 0; h <= hold; h++) begin
            chk("res_wb",    mem_to_wb_bus, {pc, we, waddr, exp_wd});
            chk("res_id",    mem_to_id,     {we, waddr, exp_wd});
            chk("res_stall", stallreq_mem,  0);
            chk("res_en",    data_sram_en,  0);
            chk("res_wen",   data_sram_wen, 0);
            if (h < hold) begin
                data_sram_data_ok = 1'($urandom_range(0, 1));
                data_sram_rdata   = $urandom;
                @(negedge clk);
                data_sram_data_ok = 1'b0;
            end
        end
        if (bub) begin
            stall = c_bubble;
            @(negedge clk);
            stall = c_hold;
            chk("bub_wb",    mem_to_wb_bus, 0);
            chk("bub_id",    mem_to_id,     0);
            chk("bub_en",    data_sram_en,  0);
            chk("bub_stall", stallreq_mem,  0);
        end
    endtask

    initial begin
        logic [3:0] op;
        int         r;
        rst               = 1'b1;
        stall             = c_run;
        ex_to_mem_bus     = {$urandom, $urandom, $urandom, $urandom};
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = $urandom;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst               = 1'b0;
        data_sram_data_ok = 1'b0;

        run_op(32'hBFC00010, 4'b0000, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0, 0, 1'b0);
        run_op(32'hBFC00014, 4'b1000, 1'b1, 5'd6, 32'h8000_0003, 32'h0, 2, 32'h80FF_1122, 0, 1'b0);
        run_op(32'hBFC00018, 4'b1001, 1'b1, 5'd7, 32'h8000_0003, 32'h0, 2, 32'h80FF_1122, 0, 1'b0);
        run_op(32'hBFC0001C, 4'b1110, 1'b0, 5'd0, 32'h8000_0002, 32'hDEADBEEF, 1, 32'h0, 0, 1'b0);
        run_op(32'hBFC00020, 4'b1100, 1'b1, 5'd9, 32'h8000_0010, 32'h0, 0, 32'hCAFE_F00D, 2, 1'b0);
        run_op(32'hBFC00024, 4'b0000, 1'b1, 5'd3, 32'h0000_5555, 32'h0, 0, 32'h0, 0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       op = 4'd0;
            else if (r == 2) op = 4'($urandom_range(1, 7));
            else             op = 4'($urandom_range(8, 15));
            run_op($urandom, op, is_store(op) ? 1'b0 : 1'($urandom_range(0, 1)),
                   5'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 5) == 0);
        end

        // Reset while waiting for a response, then a stray data_ok.
        ex_to_mem_bus = {32'hBFC00100, 4'b1100, 1'b1, 5'd4, 32'h8000_0040, 32'h0};
        stall         = c_run;
        @(negedge clk);
        stall = c_hold;
        chk("rstw_en0", data_sram_en, 1);
        @(negedge clk);
        chk("rstw_en1", data_sram_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rstw");
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        check_zero("stray");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
